wrr_arbiter: RTL



---
 rtl/arb_pkg.sv | 32 +++
 rtl/arb_pick.sv | 38 +++
 rtl/wrr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the registered arbiter family.
// Holds the mode and state enums and a one-hot to index encoder.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_SP  = 2'd0,
        ARB_RR  = 2'd1,
        ARB_WRR = 2'd2
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Widest requester vector the encoder accepts; callers truncate the result.
    localparam int MAX_NUM = 32;
    localparam int MAX_IDX_W = $clog2(MAX_NUM);

    // OR-reduction encoder: correct only for one-hot or all-zero input.
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_NUM-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM; i++) begin
            if (vec[i]) begin
                idx = idx | i[MAX_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational rotating-priority picker: first set request found when
// stepping away from the base pointer in the configured direction.
module arb_pick #(
    parameter int NUM      = 4,
    parameter bit LSB_HIGH = 1'b1,
    localparam int IDX_W   = $clog2(NUM)
) (
    input  logic [NUM-1:0]   req,
    input  logic [IDX_W-1:0] base,
    input  logic             rotate_en,
    output logic [NUM-1:0]   winner,
    output logic             valid
);

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] idx;

    // Fixed priority is a rotation anchored just before the highest-priority end.
    assign start = rotate_en ? base : (LSB_HIGH ? IDX_W'(NUM - 1) : '0);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM; k++) begin
            if (LSB_HIGH) begin
                idx = IDX_W'((int'(start) + k) % NUM);
            end else begin
                idx = IDX_W'((int'(start) + NUM - k) % NUM);
            end
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Registered strict / round-robin / weighted round-robin arbiter with
// grants held until ack or withdrawal.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM      = 4,
    parameter int WEIGHT_W = 4,
    parameter bit LSB_HIGH = 1'b1,
    parameter int MODE     = 2,
    localparam int IDX_W   = $clog2(NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM-1:0]        req,
    input  logic [NUM*WEIGHT_W-1:0] weight,
    input  logic                  ack,
    output logic [NUM-1:0]        gnt,
    output logic [IDX_W-1:0]      gnt_idx,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAST_INIT = LSB_HIGH ? IDX_W'(NUM - 1) : '0;
    localparam bit ROTATE = (MODE != int'(ARB_SP));
    localparam bit IS_WRR = (MODE == int'(ARB_WRR));

    arb_state_e          state_reg;
    logic [IDX_W-1:0]    last_idx_reg;
    logic [WEIGHT_W-1:0] credit_reg;
    logic [WEIGHT_W-1:0] stored_weight_reg;

    logic [WEIGHT_W-1:0] weight_field [NUM];

    for (genvar gi = 0; gi < NUM; gi++) begin : g_weight
        assign weight_field[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
    end

    logic [NUM-1:0]      pick_onehot;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [WEIGHT_W-1:0] pick_weight;
    logic                withdrew;
    logic                end_event;
    logic [WEIGHT_W:0]   credit_next;
    logic                keep_grant;
    logic                take_grant;
    logic                go_idle;

    // A withdrawn grantee already has its req bit low, so the raw req
    // vector naturally excludes it from re-arbitration.
    arb_pick #(
        .NUM      (NUM),
        .LSB_HIGH (LSB_HIGH)
    ) u_pick (
        .req       (req),
        .base      (last_idx_reg),
        .rotate_en (ROTATE),
        .winner    (pick_onehot),
        .valid     (pick_valid)
    );

    assign pick_idx    = IDX_W'(onehot2idx(MAX_NUM'(pick_onehot)));
    assign pick_weight = (weight_field[pick_idx] == '0) ? WEIGHT_W'(1) : weight_field[pick_idx];

    assign withdrew    = |(gnt & ~req);
    assign end_event   = ack | withdrew;
    assign credit_next = {1'b0, credit_reg} + 1'b1;
    assign keep_grant  = IS_WRR && ack && !withdrew && (credit_next < {1'b0, stored_weight_reg});

    always_comb begin
        take_grant = 1'b0;
        go_idle    = 1'b0;
        if (state_reg == ARB_IDLE) begin
            take_grant = pick_valid;
        end else if (end_event && !keep_grant) begin
            take_grant = pick_valid;
            go_idle    = !pick_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= ARB_IDLE;
            gnt               <= '0;
            gnt_idx           <= '0;
            last_idx_reg      <= LAST_INIT;
            credit_reg        <= '0;
            stored_weight_reg <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE, ARB_GRANT: begin
                    if (take_grant) begin
                        state_reg         <= ARB_GRANT;
                        gnt               <= pick_onehot;
                        gnt_idx           <= pick_idx;
                        last_idx_reg      <= pick_idx;
                        stored_weight_reg <= pick_weight;
                        credit_reg        <= '0;
                    end else if (go_idle) begin
                        state_reg  <= ARB_IDLE;
                        gnt        <= '0;
                        gnt_idx    <= '0;
                        credit_reg <= '0;
                    end else if (state_reg == ARB_GRANT && keep_grant) begin
                        credit_reg <= credit_next[WEIGHT_W-1:0];
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign busy = |gnt;

endmodule
